bus_rr_arbiter: RTL and testbench

- Shares one memory-side bus slave port between N core-side masters, e.g. instruction fetch and data load/store, or multiple cores.
- Request/grant protocol on both sides: a transaction is accepted in the cycle where req and gnt are both high. Read data returns on the cycle after read acceptance.
- Arbitration is round-robin with a starvation boost.
- The block tracks which master owns each returning read beat.

---
 rtl/bus_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_rr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter that shares one request/grant slave port between NUM_M masters.
// Long-waiting masters get a starvation boost, and each read-data beat is steered back to its owner.
module bus_rr_arbiter #(
  parameter int NUM_M    = 2,
  parameter int MAX_WAIT = 15,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_M-1:0]        m_rd_req,
  input  logic [NUM_M*AW-1:0]     m_rd_addr,
  output logic [NUM_M-1:0]        m_rd_gnt,
  output logic [NUM_M-1:0]        m_rd_valid,
  output logic [DW-1:0]           m_rd_data,
  input  logic [NUM_M-1:0]        m_wr_req,
  input  logic [NUM_M*AW-1:0]     m_wr_addr,
  input  logic [NUM_M*DW-1:0]     m_wr_data,
  input  logic [NUM_M*(DW/8)-1:0] m_wr_be,
  output logic [NUM_M-1:0]        m_wr_gnt,
  output logic                    s_rd_req,
  output logic [AW-1:0]           s_rd_addr,
  input  logic                    s_rd_gnt,
  input  logic [DW-1:0]           s_rd_data,
  output logic                    s_wr_req,
  output logic [AW-1:0]           s_wr_addr,
  output logic [DW-1:0]           s_wr_data,
  output logic [DW/8-1:0]         s_wr_be,
  input  logic                    s_wr_gnt,
  output logic [NUM_M-1:0]        o_starve
);

  localparam int PW = $clog2(NUM_M);
  localparam int CW = 8;
  localparam int BW = DW / 8;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [NUM_M-1:0]         req;
  logic [NUM_M-1:0]         boosted;
  logic [PW-1:0]            sel;
  logic [PW-1:0]            rr_idx;
  logic                     found;
  logic                     acc;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [NUM_M-1:0][CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [NUM_M-1:0]         rd_valid_q, rd_valid_d;

  assign req = m_rd_req | m_wr_req;

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      boosted[i]  = req[i] && (wait_cnt_q[i] == WAIT_MAX);
      o_starve[i] = (wait_cnt_q[i] == WAIT_MAX);
    end
  end

  // A boosted master overrides the rotation; among several, the lowest index wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel    = '0;
    rr_idx = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!found && boosted[i]) begin
        sel   = PW'(i);
        found = 1'b1;
      end
    end
    for (int k = 1; k <= NUM_M; k++) begin
      rr_idx = PW'((int'(ptr_q) + k) % NUM_M);
      if (!found && req[rr_idx]) begin
        sel   = rr_idx;
        found = 1'b1;
      end
    end
  end

  // A read takes priority over a write from the same master; the write stays pending.
  assign s_rd_req  = found & m_rd_req[sel];
  assign s_wr_req  = found & m_wr_req[sel] & ~m_rd_req[sel];
  assign s_rd_addr = m_rd_addr[sel*AW +: AW];
  assign s_wr_addr = m_wr_addr[sel*AW +: AW];
  assign s_wr_data = m_wr_data[sel*DW +: DW];
  assign s_wr_be   = m_wr_be[sel*BW +: BW];
  assign m_rd_data = s_rd_data;

  always_comb begin
    m_rd_gnt      = '0;
    m_wr_gnt      = '0;
    m_rd_gnt[sel] = s_rd_req & s_rd_gnt;
    m_wr_gnt[sel] = s_wr_req & s_wr_gnt;
  end

  assign acc        = (|m_rd_gnt) | (|m_wr_gnt);
  assign ptr_d      = acc ? sel : ptr_q;
  assign rd_valid_d = m_rd_gnt;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    for (int i = 0; i < NUM_M; i++) begin
      if (!req[i] || m_rd_gnt[i] || m_wr_gnt[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != WAIT_MAX) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end
    end
  end

  assign m_rd_valid = rd_valid_q;

  // Reset leaves the pointer on the last master so master 0 is served first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PW'(NUM_M - 1);
      wait_cnt_q <= '0;
      rd_valid_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      ptr_q      <= ptr_d;
      wait_cnt_q <= wait_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed stimulus pushes expectations into a
// cycle-stamped scoreboard, which is drained and compared each cycle.
module tb_bus_rr_arbiter;

  localparam int NUM_M    = 3;
  localparam int MAX_WAIT = 3;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int BW       = DW / 8;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_M-1:0]      m_rd_req;
  logic [NUM_M*AW-1:0]   m_rd_addr;
  logic [NUM_M-1:0]      m_rd_gnt;
  logic [NUM_M-1:0]      m_rd_valid;
  logic [DW-1:0]         m_rd_data;
  logic [NUM_M-1:0]      m_wr_req;
  logic [NUM_M*AW-1:0]   m_wr_addr;
  logic [NUM_M*DW-1:0]   m_wr_data;
  logic [NUM_M*BW-1:0]   m_wr_be;
  logic [NUM_M-1:0]      m_wr_gnt;
  logic                  s_rd_req;
  logic [AW-1:0]         s_rd_addr;
  logic                  s_rd_gnt;
  logic [DW-1:0]         s_rd_data;
  logic                  s_wr_req;
  logic [AW-1:0]         s_wr_addr;
  logic [DW-1:0]         s_wr_data;
  logic [BW-1:0]         s_wr_be;
  logic                  s_wr_gnt;
  logic [NUM_M-1:0]      o_starve;

  bus_rr_arbiter #(.NUM_M(NUM_M), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_gnt(m_rd_gnt),
    .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_be(m_wr_be), .m_wr_gnt(m_wr_gnt),
    .s_rd_req(s_rd_req), .s_rd_addr(s_rd_addr), .s_rd_gnt(s_rd_gnt), .s_rd_data(s_rd_data),
    .s_wr_req(s_wr_req), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data), .s_wr_be(s_wr_be),
    .s_wr_gnt(s_wr_gnt), .o_starve(o_starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_RD_GNT, K_WR_GNT, K_RD_VALID, K_RD_DATA, K_STARVE, K_S_RD_REQ,
                K_S_WR_REQ, K_S_RD_ADDR, K_S_WR_ADDR, K_S_WR_DATA, K_S_WR_BE} kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_RD_GNT:    return 32'(m_rd_gnt);
      K_WR_GNT:    return 32'(m_wr_gnt);
      K_RD_VALID:  return 32'(m_rd_valid);
      K_RD_DATA:   return 32'(m_rd_data);
      K_STARVE:    return 32'(o_starve);
      K_S_RD_REQ:  return 32'(s_rd_req);
      K_S_WR_REQ:  return 32'(s_wr_req);
      K_S_RD_ADDR: return 32'(s_rd_addr);
      K_S_WR_ADDR: return 32'(s_wr_addr);
      K_S_WR_DATA: return 32'(s_wr_data);
      K_S_WR_BE:   return 32'(s_wr_be);
      default:     return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push(input int dc, input kind_e k, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc  = cyc + dc;
    e.kind = k;
    e.val  = v;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Read grant this cycle and the matching valid one cycle later.
  task automatic exp_rd(input logic [31:0] v, input string tag);
    push(0, K_RD_GNT, v, {tag, "_rd_gnt"});
    push(1, K_RD_VALID, v, {tag, "_rd_valid"});
  endtask

  // Inputs are already driven; let them settle, drain this cycle's expectations, advance.
  task automatic cycle();
    #2;
    for (int i = 0; i < sb_q.size(); ) begin
      if (sb_q[i].cyc <= cyc) begin
        check(sb_q[i].tag, observe(sb_q[i].kind), sb_q[i].val);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    m_rd_req  = '0;
    m_wr_req  = '0;
    s_rd_gnt  = 1'b0;
    s_wr_gnt  = 1'b0;
    s_rd_data = '0;
  endtask

  task automatic set_rd_addr(input int m, input logic [AW-1:0] a);
    m_rd_addr[m*AW +: AW] = a;
  endtask

  initial begin
    rst_n     = 1'b0;
    m_rd_addr = '0;
    m_wr_addr = '0;
    m_wr_data = '0;
    m_wr_be   = '0;
    idle();
    @(negedge clk);
    #1;

    // Reset state with no requests
    push(0, K_RD_GNT, 0, "rst_rd_gnt");
    push(0, K_WR_GNT, 0, "rst_wr_gnt");
    push(0, K_RD_VALID, 0, "rst_rd_valid");
    push(0, K_STARVE, 0, "rst_starve");
    push(0, K_S_RD_REQ, 0, "rst_s_rd_req");
    push(0, K_S_WR_REQ, 0, "rst_s_wr_req");
    cycle();
    rst_n = 1'b1;

    // Two masters reading continuously alternate, master 0 first
    idle();
    m_rd_req = 3'b011;
    s_rd_gnt = 1'b1;
    set_rd_addr(0, 32'h1000);
    set_rd_addr(1, 32'h1004);
    for (int k = 0; k < 4; k++) begin
      exp_rd((k % 2 == 0) ? 32'h1 : 32'h2, "alt");
      push(0, K_S_RD_ADDR, (k % 2 == 0) ? 32'h1000 : 32'h1004, "alt_addr");
      cycle();
    end

    // Stall with masters 1 and 2 waiting: boost picks master 1 over the rotation's master 2
    idle();
    m_rd_req = 3'b110;
    for (int k = 0; k < 3; k++) begin
      exp_rd(0, "stall");
      push(0, K_STARVE, 0, "stall_starve");
      cycle();
    end
    s_rd_gnt = 1'b1;
    push(0, K_STARVE, 32'h6, "boost_starve");
    exp_rd(32'h2, "boost_m1");
    cycle();
    m_rd_req = 3'b101;
    push(0, K_STARVE, 32'h4, "boost_sat_starve");
    exp_rd(32'h4, "boost_m2");
    cycle();
    m_rd_req = 3'b001;
    push(0, K_STARVE, 0, "boost_clear_starve");
    exp_rd(32'h1, "boost_m0");
    cycle();

    // Single read from master 1 with data returned next cycle
    idle();
    m_rd_req = 3'b010;
    s_rd_gnt = 1'b1;
    set_rd_addr(1, 32'h100);
    exp_rd(32'h2, "m1_read");
    push(0, K_S_RD_ADDR, 32'h100, "m1_read_addr");
    cycle();
    idle();
    s_rd_data = 32'hDEAD_BEEF;
    push(0, K_RD_DATA, 32'hDEAD_BEEF, "m1_read_data");
    exp_rd(0, "m1_read_after");
    cycle();

    // Master 0 starves under a stalled slave, then is served
    idle();
    m_rd_req = 3'b001;
    set_rd_addr(0, 32'h40);
    for (int k = 0; k < 4; k++) begin
      exp_rd(0, "starve_stall");
      push(0, K_STARVE, (k == 3) ? 32'h1 : 32'h0, "starve_cnt");
      cycle();
    end
    s_rd_gnt = 1'b1;
    exp_rd(32'h1, "starve_grant");
    push(0, K_STARVE, 32'h1, "starve_hold");
    cycle();
    idle();
    exp_rd(0, "starve_done");
    push(0, K_STARVE, 0, "starve_cleared");
    cycle();

    // Read and write together from master 0: read first, write next cycle
    idle();
    m_rd_req = 3'b001;
    m_wr_req = 3'b001;
    s_rd_gnt = 1'b1;
    s_wr_gnt = 1'b1;
    set_rd_addr(0, 32'h10);
    m_wr_addr[0 +: AW] = 32'h20;
    m_wr_data[0 +: DW] = 32'h55;
    m_wr_be[0 +: BW]   = 4'hF;
    exp_rd(32'h1, "rw_read");
    push(0, K_WR_GNT, 0, "rw_wr_held");
    push(0, K_S_WR_REQ, 0, "rw_s_wr_req_held");
    push(0, K_S_RD_ADDR, 32'h10, "rw_rd_addr");
    cycle();
    m_rd_req = 3'b000;
    exp_rd(0, "rw_write");
    push(0, K_WR_GNT, 32'h1, "rw_wr_gnt");
    push(0, K_S_WR_REQ, 32'h1, "rw_s_wr_req");
    push(0, K_S_WR_ADDR, 32'h20, "rw_wr_addr");
    push(0, K_S_WR_DATA, 32'h55, "rw_wr_data");
    push(0, K_S_WR_BE, 32'hF, "rw_wr_be");
    cycle();
    idle();
    exp_rd(0, "rw_idle");
    push(0, K_WR_GNT, 0, "rw_idle_wr_gnt");
    cycle();

    // Read accepted, then reset before its data beat: no valid, pointer restarts at master 0
    idle();
    m_rd_req = 3'b001;
    s_rd_gnt = 1'b1;
    push(0, K_RD_GNT, 32'h1, "rst_mid_gnt");
    cycle();
    idle();
    rst_n = 1'b0;
    push(0, K_RD_VALID, 0, "rst_mid_valid");
    push(0, K_RD_GNT, 0, "rst_mid_no_gnt");
    cycle();
    rst_n    = 1'b1;
    m_rd_req = 3'b011;
    s_rd_gnt = 1'b1;
    exp_rd(32'h1, "post_rst_m0");
    cycle();
    m_rd_req = 3'b010;
    exp_rd(32'h2, "post_rst_m1");
    cycle();
    idle();
    exp_rd(0, "post_rst_idle");
    cycle();
    cycle();

    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
